pc_gen: RTL and testbench



---
 rtl/npc_pkg.sv | 24 ++
 rtl/br_resolve.sv | 43 ++++
 rtl/pc_gen.sv | 115 +++++++++++
 tb/tb_pc_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the npc core front end: branch-type encodings,
// the PC generator state enum and the default reset PC.
package npc_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // Control-flow encodings presented by execute; value 3 behaves as BR_SEQ.
    typedef enum logic [2:0] {
        BR_SEQ  = 3'd0,
        BR_JAL  = 3'd1,
        BR_JALR = 3'd2,
        BR_EQ   = 3'd4,
        BR_NE   = 3'd5,
        BR_GE   = 3'd6,
        BR_LT   = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/br_resolve.sv
// Combinational branch resolution: decides whether a control-flow
// instruction is taken, computes its target and flags a misaligned target.
// Kept separate so a future predictor checker can reuse it.
module br_resolve
    import npc_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int IALIGN = 32
) (
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1,
    input  logic            br_zero,
    input  logic            br_less,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] sum;

    // Taken decision, target address (bit 0 dropped) and alignment check.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_JAL,
            BR_JALR: taken = 1'b1;
            BR_EQ:   taken = br_zero;
            BR_NE:   taken = !br_zero;
            BR_GE:   taken = !br_less;
            BR_LT:   taken = br_less;
            default: taken = 1'b0;
        endcase

        sum      = br_imm + ((br_type_e'(br_type) == BR_JALR) ? br_rs1 : br_pc);
        target   = {sum[XLEN-1:1], 1'b0};
        misalign = (IALIGN == 32) ? target[1] : 1'b0;
    end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter front end. Holds the fetch PC, advances it under
// the IFU valid/ready handshake and applies trap and branch redirects with a
// one-cycle flush pulse. Counts applied redirects and supports a sticky halt.
module pc_gen
    import npc_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              IALIGN   = 32,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic             if_flush,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic [XLEN-1:0]  br_rs1,
    input  logic             br_zero,
    input  logic             br_less,
    output logic             br_misalign,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             halt_req,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             br_mis;

    br_resolve #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_br_resolve (
        .br_type  (br_type),
        .br_pc    (br_pc),
        .br_imm   (br_imm),
        .br_rs1   (br_rs1),
        .br_zero  (br_zero),
        .br_less  (br_less),
        .taken    (br_taken),
        .target   (br_target),
        .misalign (br_mis)
    );

    // Next-state logic: halt > trap > aligned taken branch > misaligned taken
    // branch (report only) > handshake advance > hold. BOOT and HALT ignore inputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (trap_valid) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (br_valid && br_taken && !br_mis) begin
                    pc_d    = br_target;
                    flush_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (br_valid && br_taken) begin
                    mis_d = 1'b1;
                end else if (if_ready) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            default: ;
        endcase
    end

    // State and output registers, all returned to reset values asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign if_valid     = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALT);
    assign pc_out       = pc_q;
    assign if_flush     = flush_q;
    assign br_misalign  = mis_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a table of per-cycle stimulus with the
// outputs expected after the following clock edge, fed through a scoreboard
// queue, plus hand-written reset sequences.
module tb_pc_gen;

    localparam logic [63:0] B = 64'h8000_0000;
    localparam logic [63:0] Z = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [63:0] pc_out;
    logic        if_flush;
    logic        br_valid;
    logic [2:0]  br_type;
    logic [63:0] br_pc, br_imm, br_rs1;
    logic        br_zero, br_less, br_misalign;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic        halt_req, halted;
    logic [31:0] redirect_cnt;

    int n_vec = 0;
    int n_err = 0;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .pc_out       (pc_out),
        .if_flush     (if_flush),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .br_pc        (br_pc),
        .br_imm       (br_imm),
        .br_rs1       (br_rs1),
        .br_zero      (br_zero),
        .br_less      (br_less),
        .br_misalign  (br_misalign),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .halt_req     (halt_req),
        .halted       (halted),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rdy;
        logic        bv;
        logic [2:0]  bt;
        logic [63:0] bpc, bimm, brs1;
        logic        bz, bl;
        logic        tv;
        logic [63:0] tpc;
        logic        hr;
        logic [63:0] e_pc;
        logic        e_valid, e_flush, e_mis, e_halted;
        logic [31:0] e_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] e_pc;
        logic        e_valid, e_flush, e_mis, e_halted;
        logic [31:0] e_cnt;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input string field,
                         input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic compare_front();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: empty queue at compare");
            return;
        end
        e = sb.pop_front();
        check(e.name, "pc_out",       pc_out,             e.e_pc);
        check(e.name, "if_valid",     64'(if_valid),      64'(e.e_valid));
        check(e.name, "if_flush",     64'(if_flush),      64'(e.e_flush));
        check(e.name, "br_misalign",  64'(br_misalign),   64'(e.e_mis));
        check(e.name, "halted",       64'(halted),        64'(e.e_halted));
        check(e.name, "redirect_cnt", 64'(redirect_cnt),  64'(e.e_cnt));
    endtask

    task automatic expect_now(input string name, input logic [63:0] pc,
                              input logic v, input logic f, input logic m,
                              input logic h, input logic [31:0] c);
        sb.push_back('{name, pc, v, f, m, h, c});
        compare_front();
    endtask

    // Drive one cycle of stimulus, queue its expectation, sample after the edge.
    task automatic apply(input vec_t v);
        if_ready   = v.rdy;
        br_valid   = v.bv;
        br_type    = v.bt;
        br_pc      = v.bpc;
        br_imm     = v.bimm;
        br_rs1     = v.brs1;
        br_zero    = v.bz;
        br_less    = v.bl;
        trap_valid = v.tv;
        trap_pc    = v.tpc;
        halt_req   = v.hr;
        sb.push_back('{v.name, v.e_pc, v.e_valid, v.e_flush, v.e_mis, v.e_halted, v.e_cnt});
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[21];
        vec_t idle;

        // name         rdy bv  bt    bpc         bimm                   brs1                    bz   bl   tv   tpc          hr    e_pc                  v    f    m    h    cnt
        vecs[0]  = '{"boot",     1, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 0, Z,             0,   B,                    1, 0, 0, 0, 0};
        vecs[1]  = '{"adv1",     1, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 0, Z,             0,   B + 4,                1, 0, 0, 0, 0};
        vecs[2]  = '{"adv2",     1, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 0, Z,             0,   B + 8,                1, 0, 0, 0, 0};
        vecs[3]  = '{"beq_tk",   1, 1, 3'd4, B + 'h10,   64'hFFFF_FFFF_FFFF_FFF0, Z,                   1, 0, 0, Z,             0,   B,                    1, 1, 0, 0, 1};
        vecs[4]  = '{"beq_nt",   0, 1, 3'd4, B + 'h10,   64'hFFFF_FFFF_FFFF_FFF0, Z,                   0, 0, 0, Z,             0,   B,                    1, 0, 0, 0, 1};
        vecs[5]  = '{"bne_tk",   1, 1, 3'd5, B + 'h20,   64'h20,                Z,                     0, 0, 0, Z,             0,   B + 'h40,             1, 1, 0, 0, 2};
        vecs[6]  = '{"bge_nt",   1, 1, 3'd6, B + 'h40,   64'h20,                Z,                     0, 1, 0, Z,             0,   B + 'h44,             1, 0, 0, 0, 2};
        vecs[7]  = '{"blt_tk",   1, 1, 3'd7, B + 'h44,   64'hFFFF_FFFF_FFFF_FFFC, Z,                   0, 1, 0, Z,             0,   B + 'h40,             1, 1, 0, 0, 3};
        vecs[8]  = '{"jalr_b0",  1, 1, 3'd2, Z,          Z,                     B + 'h101,             0, 0, 0, Z,             0,   B + 'h100,            1, 1, 0, 0, 4};
        vecs[9]  = '{"jalr_mis", 1, 1, 3'd2, Z,          Z,                     B + 'h102,             0, 0, 0, Z,             0,   B + 'h100,            1, 0, 1, 0, 4};
        vecs[10] = '{"trap_jal", 1, 1, 3'd1, B + 'h100,  64'h10,                Z,                     0, 0, 1, B + 'h1000,    0,   B + 'h1000,           1, 1, 0, 0, 5};
        vecs[11] = '{"type3",    1, 1, 3'd3, B + 'h1000, 64'h40,                Z,                     1, 1, 0, Z,             0,   B + 'h1004,           1, 0, 0, 0, 5};
        vecs[12] = '{"jal_a",    0, 1, 3'd1, B + 'h1004, 64'h8,                 Z,                     0, 0, 0, Z,             0,   B + 'h100C,           1, 1, 0, 0, 6};
        vecs[13] = '{"jal_b",    0, 1, 3'd1, B + 'h100C, 64'hFFFF_FFFF_FFFF_FFF4, Z,                   0, 0, 0, Z,             0,   B + 'h1000,           1, 1, 0, 0, 7};
        vecs[14] = '{"stall1",   0, 1, 3'd0, B + 'h1000, 64'h40,                Z,                     0, 0, 0, Z,             0,   B + 'h1000,           1, 0, 0, 0, 7};
        vecs[15] = '{"stall2",   0, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 0, Z,             0,   B + 'h1000,           1, 0, 0, 0, 7};
        vecs[16] = '{"stall3",   0, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 0, Z,             0,   B + 'h1000,           1, 0, 0, 0, 7};
        vecs[17] = '{"stall4",   0, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 0, Z,             0,   B + 'h1000,           1, 0, 0, 0, 7};
        vecs[18] = '{"jalr_wrap",1, 1, 3'd2, Z,          64'h8,                 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, Z,           0,   64'h4,                1, 1, 0, 0, 8};
        vecs[19] = '{"halt",     0, 0, 3'd0, Z,          Z,                     Z,                     0, 0, 1, B + 'h2000,    1,   64'h4,                0, 0, 0, 1, 8};
        vecs[20] = '{"halt_ign", 1, 1, 3'd1, B,          64'h100,               Z,                     0, 0, 1, B + 'h2000,    1,   64'h4,                0, 0, 0, 1, 8};

        idle = vecs[15];

        // Power-on reset held across two edges.
        rst = 1'b1;
        if_ready = 0; br_valid = 0; br_type = 0; br_pc = 0; br_imm = 0; br_rs1 = 0;
        br_zero = 0; br_less = 0; trap_valid = 0; trap_pc = 0; halt_req = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset", B, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) apply(vecs[i]);

        // Asynchronous reset while halted and stalled, mid-cycle.
        idle.rdy = 0;
        if_ready = 0;
        #3 rst = 1'b1;
        #1;
        expect_now("rst_async", B, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        expect_now("rst_held", B, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Restart: one BOOT edge, then fetch resumes at the reset PC.
        idle.rdy = 1;
        idle.name = "reboot"; idle.e_pc = B;     idle.e_valid = 1; idle.e_cnt = 0;
        apply(idle);
        idle.name = "readv";  idle.e_pc = B + 4;
        apply(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
